// File: rtl/src_mux_fwd_pkg.sv
// Shared encodings for the EX-stage source mux: ALU source selectors and forwarding-source codes.
package src_mux_fwd_pkg;

  localparam int NUM_PORTS = 2;

  localparam logic [1:0] RF2SRC0       = 2'd0;
  localparam logic [1:0] IMM_BR2SRC0   = 2'd1;
  localparam logic [1:0] IMM_JMP2SRC0  = 2'd2;
  localparam logic [1:0] IMM_ADDR2SRC0 = 2'd3;

  localparam logic [1:0] RF2SRC1       = 2'd0;
  localparam logic [1:0] NPC2SRC1      = 2'd1;
  localparam logic [1:0] IMM2SRC1_4BSE = 2'd2;
  localparam logic [1:0] IMM_LHB2SRC1  = 2'd3;

  typedef enum logic [1:0] {
    FWD_RF = 2'd0,
    FWD_EX = 2'd1,
    FWD_DM = 2'd2
  } fwd_e;

endpackage

// File: rtl/src_mux_fwd_port.sv
// One register-source lane: ID_EX operand flops, write-back refresh while stalled,
// and the EX_DM / DM_WB forwarding priority mux.
module src_fwd_port
  import src_mux_fwd_pkg::*;
#(
  parameter int DATA_W   = 17,
  parameter int RADDR_W  = 4,
  parameter int ZERO_REG = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               flush,
  input  logic [RADDR_W-1:0] rs_addr,
  input  logic               rs_re,
  input  logic [DATA_W-1:0]  rf_data,
  input  logic [DATA_W-1:0]  dst_ex,
  input  logic [RADDR_W-1:0] dst_addr_ex,
  input  logic               we_ex,
  input  logic               ld_ex,
  input  logic [DATA_W-1:0]  dst_dm,
  input  logic [RADDR_W-1:0] dst_addr_dm,
  input  logic               we_dm,
  output logic [DATA_W-1:0]  data,
  output logic [1:0]         fwd,
  output logic               hit_ex
);

  logic [DATA_W-1:0]  p_q;
  logic [RADDR_W-1:0] rs_q;
  logic               re_q;
  logic               nz_in, nz_q, hit_dm;

  assign nz_in = !((ZERO_REG != 0) && (rs_addr == '0));
  assign nz_q  = !((ZERO_REG != 0) && (rs_q == '0));

  always_ff @(posedge clk) begin
    if (rst) begin
      p_q  <= '0;
      rs_q <= '0;
      re_q <= 1'b0;
    end else if (stall) begin
      // keep the held operand coherent with whatever retires underneath the stall
      if (re_q && we_dm && (dst_addr_dm == rs_q) && nz_q)
        p_q <= dst_dm;
    end else if (flush) begin
      p_q  <= '0;
      rs_q <= '0;
      re_q <= 1'b0;
    end else begin
      rs_q <= rs_addr;
      re_q <= rs_re;
      // RF is read-before-write, so catch the same-cycle write-back here
      p_q  <= (we_dm && (dst_addr_dm == rs_addr) && nz_in) ? dst_dm : rf_data;
    end
  end

  assign hit_ex = re_q && we_ex && (dst_addr_ex == rs_q) && nz_q;
  assign hit_dm = re_q && we_dm && (dst_addr_dm == rs_q) && nz_q;

  // EX_DM is the newer result, but a load's EX_DM value is an address, not data
  always_comb begin
    data = p_q;
    fwd  = FWD_RF;
    if (hit_ex && !ld_ex) begin
      data = dst_ex;
      fwd  = FWD_EX;
    end else if (hit_dm) begin
      data = dst_dm;
      fwd  = FWD_DM;
    end
  end

endmodule

// File: rtl/src_mux_fwd.sv
// EX-stage source mux with internal forwarding, load-use detection and store-data pipelining.
module src_mux_fwd
  import src_mux_fwd_pkg::*;
#(
  parameter int DATA_W   = 17,
  parameter int RADDR_W  = 4,
  parameter int IMM_W    = 12,
  parameter int BR_W     = 9,
  parameter int JMP_W    = 12,
  parameter int ADDR_W   = 4,
  parameter int LHB_W    = 8,
  parameter int ZERO_REG = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall_ID_EX,
  input  logic               stall_EX_DM,
  input  logic               flush_ID_EX,
  input  logic [RADDR_W-1:0] rs0_addr,
  input  logic [RADDR_W-1:0] rs1_addr,
  input  logic               rs0_re,
  input  logic               rs1_re,
  input  logic [DATA_W-1:0]  p0,
  input  logic [DATA_W-1:0]  p1,
  input  logic [1:0]         src0sel_ID_EX,
  input  logic [1:0]         src1sel_ID_EX,
  input  logic [IMM_W-1:0]   imm_ID_EX,
  input  logic [DATA_W-1:0]  pc_ID_EX,
  input  logic [DATA_W-1:0]  dst_EX_DM,
  input  logic [DATA_W-1:0]  dst_DM_WB,
  input  logic [RADDR_W-1:0] dst_addr_EX_DM,
  input  logic [RADDR_W-1:0] dst_addr_DM_WB,
  input  logic               we_EX_DM,
  input  logic               we_DM_WB,
  input  logic               ld_EX_DM,
  output logic [DATA_W-1:0]  src0,
  output logic [DATA_W-1:0]  src1,
  output logic [DATA_W-1:0]  p0_EX_DM,
  output logic [1:0]         fwd0,
  output logic [1:0]         fwd1,
  output logic               load_use_hz
);

  logic [NUM_PORTS-1:0][RADDR_W-1:0] rs_addr_v;
  logic [NUM_PORTS-1:0]              rs_re_v, hit_ex_v;
  logic [NUM_PORTS-1:0][DATA_W-1:0]  rf_v, p_v;
  logic [NUM_PORTS-1:0][1:0]         fwd_v;

  assign rs_addr_v = {rs1_addr, rs0_addr};
  assign rs_re_v   = {rs1_re, rs0_re};
  assign rf_v      = {p1, p0};

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
    src_fwd_port #(
      .DATA_W  (DATA_W),
      .RADDR_W (RADDR_W),
      .ZERO_REG(ZERO_REG)
    ) u_port (
      .clk        (clk),
      .rst        (rst),
      .stall      (stall_ID_EX),
      .flush      (flush_ID_EX),
      .rs_addr    (rs_addr_v[i]),
      .rs_re      (rs_re_v[i]),
      .rf_data    (rf_v[i]),
      .dst_ex     (dst_EX_DM),
      .dst_addr_ex(dst_addr_EX_DM),
      .we_ex      (we_EX_DM),
      .ld_ex      (ld_EX_DM),
      .dst_dm     (dst_DM_WB),
      .dst_addr_dm(dst_addr_DM_WB),
      .we_dm      (we_DM_WB),
      .data       (p_v[i]),
      .fwd        (fwd_v[i]),
      .hit_ex     (hit_ex_v[i])
    );
  end

  assign fwd0        = fwd_v[0];
  assign fwd1        = fwd_v[1];
  assign load_use_hz = ld_EX_DM && (|hit_ex_v);

  logic [DATA_W-1:0] imm_br, imm_jmp, imm_addr, imm_lhb;
  assign imm_br   = {{(DATA_W-BR_W){imm_ID_EX[BR_W-1]}},     imm_ID_EX[BR_W-1:0]};
  assign imm_jmp  = {{(DATA_W-JMP_W){imm_ID_EX[JMP_W-1]}},   imm_ID_EX[JMP_W-1:0]};
  assign imm_addr = {{(DATA_W-ADDR_W){imm_ID_EX[ADDR_W-1]}}, imm_ID_EX[ADDR_W-1:0]};
  assign imm_lhb  = {{(DATA_W-LHB_W){imm_ID_EX[LHB_W-1]}},   imm_ID_EX[LHB_W-1:0]};

  always_comb begin
    case (src0sel_ID_EX)
      RF2SRC0:      src0 = p_v[0];
      IMM_BR2SRC0:  src0 = imm_br;
      IMM_JMP2SRC0: src0 = imm_jmp;
      default:      src0 = imm_addr;
    endcase
  end

  always_comb begin
    case (src1sel_ID_EX)
      RF2SRC1:       src1 = p_v[1];
      NPC2SRC1:      src1 = pc_ID_EX;
      IMM2SRC1_4BSE: src1 = imm_addr;
      default:       src1 = imm_lhb;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)
      p0_EX_DM <= '0;
    else if (!stall_EX_DM)
      p0_EX_DM <= p_v[0];
  end

endmodule

// File: tb/tb_src_mux_fwd.sv
// Bench for src_mux_fwd: directed pipeline scenarios plus randomized traffic against a rule-level model.
module tb_src_mux_fwd;
  import src_mux_fwd_pkg::*;

  logic        clk = 1'b0;
  logic        rst, stall_ID_EX, stall_EX_DM, flush_ID_EX;
  logic [3:0]  rs0_addr, rs1_addr, dst_addr_EX_DM, dst_addr_DM_WB;
  logic        rs0_re, rs1_re, we_EX_DM, we_DM_WB, ld_EX_DM;
  logic [16:0] p0, p1, pc_ID_EX, dst_EX_DM, dst_DM_WB;
  logic [1:0]  src0sel_ID_EX, src1sel_ID_EX;
  logic [11:0] imm_ID_EX;
  logic [16:0] src0, src1, p0_EX_DM;
  logic [1:0]  fwd0, fwd1;
  logic        load_use_hz;

  int n_chk = 0;
  int n_pass = 0;

  src_mux_fwd dut (
    .clk(clk), .rst(rst), .stall_ID_EX(stall_ID_EX), .stall_EX_DM(stall_EX_DM),
    .flush_ID_EX(flush_ID_EX), .rs0_addr(rs0_addr), .rs1_addr(rs1_addr),
    .rs0_re(rs0_re), .rs1_re(rs1_re), .p0(p0), .p1(p1),
    .src0sel_ID_EX(src0sel_ID_EX), .src1sel_ID_EX(src1sel_ID_EX), .imm_ID_EX(imm_ID_EX),
    .pc_ID_EX(pc_ID_EX), .dst_EX_DM(dst_EX_DM), .dst_DM_WB(dst_DM_WB),
    .dst_addr_EX_DM(dst_addr_EX_DM), .dst_addr_DM_WB(dst_addr_DM_WB),
    .we_EX_DM(we_EX_DM), .we_DM_WB(we_DM_WB), .ld_EX_DM(ld_EX_DM),
    .src0(src0), .src1(src1), .p0_EX_DM(p0_EX_DM), .fwd0(fwd0), .fwd1(fwd1),
    .load_use_hz(load_use_hz)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    rst = 0; stall_ID_EX = 0; stall_EX_DM = 0; flush_ID_EX = 0;
    rs0_addr = 0; rs1_addr = 0; rs0_re = 0; rs1_re = 0; p0 = 0; p1 = 0;
    src0sel_ID_EX = RF2SRC0; src1sel_ID_EX = RF2SRC1; imm_ID_EX = 0; pc_ID_EX = 0;
    dst_EX_DM = 0; dst_DM_WB = 0; dst_addr_EX_DM = 0; dst_addr_DM_WB = 0;
    we_EX_DM = 0; we_DM_WB = 0; ld_EX_DM = 0;
  endtask

  function automatic logic [16:0] sx(input logic [11:0] v, input int w);
    logic [16:0] r;
    r = {5'd0, v} & ((17'h1 << w) - 17'h1);
    if (v[w-1]) r = r | (17'h1FFFF << w);
    return r;
  endfunction

  task automatic test_reset();
    idle(); rst = 1; tick(); tick(); rst = 0;
    @(negedge clk);
    n_chk++; if (src0 !== 17'h0) $display("FAIL reset_src0: got %h exp 0", src0); else n_pass++;
    n_chk++; if (src1 !== 17'h0) $display("FAIL reset_src1: got %h exp 0", src1); else n_pass++;
    n_chk++; if (p0_EX_DM !== 17'h0) $display("FAIL reset_st: got %h exp 0", p0_EX_DM); else n_pass++;
    n_chk++; if ({fwd0, fwd1, load_use_hz} !== 5'b0) $display("FAIL reset_ctl: got %b exp 0", {fwd0, fwd1, load_use_hz}); else n_pass++;
    tick();
  endtask

  task automatic test_ex_fwd();
    idle(); rs0_addr = 3; rs0_re = 1; p0 = 17'h00555; tick();
    idle(); we_EX_DM = 1; dst_addr_EX_DM = 3; dst_EX_DM = 17'h1ABCD;
    @(negedge clk);
    n_chk++; if (src0 !== 17'h1ABCD) $display("FAIL ex_fwd_src0: got %h exp 1abcd", src0); else n_pass++;
    n_chk++; if (fwd0 !== 2'd1) $display("FAIL ex_fwd_fwd0: got %0d exp 1", fwd0); else n_pass++;
    tick();
  endtask

  task automatic test_priority();
    idle(); rs1_addr = 5; rs1_re = 1; p1 = 17'h00999; tick();
    idle(); we_EX_DM = 1; dst_addr_EX_DM = 5; dst_EX_DM = 17'h00011;
    we_DM_WB = 1; dst_addr_DM_WB = 5; dst_DM_WB = 17'h00022;
    @(negedge clk);
    n_chk++; if (src1 !== 17'h00011) $display("FAIL prio_src1: got %h exp 00011", src1); else n_pass++;
    n_chk++; if (fwd1 !== 2'd1) $display("FAIL prio_fwd1: got %0d exp 1", fwd1); else n_pass++;
    tick();
  endtask

  task automatic test_stall_refresh();
    idle(); rs0_addr = 7; rs0_re = 1; p0 = 17'h00001; tick();
    idle(); stall_ID_EX = 1; rs0_addr = 9; rs0_re = 1; p0 = 17'h12345;
    we_DM_WB = 1; dst_addr_DM_WB = 7; dst_DM_WB = 17'h0BEEF; tick();
    we_DM_WB = 0; dst_addr_DM_WB = 0; dst_DM_WB = 0; flush_ID_EX = 1; tick();
    idle();
    @(negedge clk);
    n_chk++; if (src0 !== 17'h0BEEF) $display("FAIL stall_src0: got %h exp 0beef", src0); else n_pass++;
    n_chk++; if (fwd0 !== 2'd0) $display("FAIL stall_fwd0: got %0d exp 0", fwd0); else n_pass++;
    tick();
  endtask

  task automatic test_load_use();
    idle(); rs1_addr = 2; rs1_re = 1; p1 = 17'h00333; tick();
    idle(); ld_EX_DM = 1; we_EX_DM = 1; dst_addr_EX_DM = 2; dst_EX_DM = 17'h00100; stall_ID_EX = 1;
    @(negedge clk);
    n_chk++; if (load_use_hz !== 1'b1) $display("FAIL lu_hz_set: got %b exp 1", load_use_hz); else n_pass++;
    tick();
    idle(); we_DM_WB = 1; dst_addr_DM_WB = 2; dst_DM_WB = 17'h00042;
    @(negedge clk);
    n_chk++; if (src1 !== 17'h00042) $display("FAIL lu_src1: got %h exp 00042", src1); else n_pass++;
    n_chk++; if (load_use_hz !== 1'b0) $display("FAIL lu_hz_clr: got %b exp 0", load_use_hz); else n_pass++;
    n_chk++; if (fwd1 !== 2'd2) $display("FAIL lu_fwd1: got %0d exp 2", fwd1); else n_pass++;
    tick();
  endtask

  task automatic test_zero_reg();
    idle(); rs0_addr = 0; rs0_re = 1; p0 = 17'h0; tick();
    idle(); we_EX_DM = 1; ld_EX_DM = 1; dst_addr_EX_DM = 0; dst_EX_DM = 17'h1FFFF;
    @(negedge clk);
    n_chk++; if (src0 !== 17'h0) $display("FAIL zr_src0: got %h exp 0", src0); else n_pass++;
    n_chk++; if (fwd0 !== 2'd0) $display("FAIL zr_fwd0: got %0d exp 0", fwd0); else n_pass++;
    n_chk++; if (load_use_hz !== 1'b0) $display("FAIL zr_hz: got %b exp 0", load_use_hz); else n_pass++;
    tick();
  endtask

  task automatic test_imm_and_rst();
    logic [1:0]  s0sel [3] = '{IMM_BR2SRC0, IMM_JMP2SRC0, IMM_ADDR2SRC0};
    logic [16:0] s0exp [3] = '{17'h1FFF0, 17'h001F0, 17'h00000};
    idle(); imm_ID_EX = 12'h1F0; src1sel_ID_EX = IMM_LHB2SRC1;
    for (int k = 0; k < 3; k++) begin
      src0sel_ID_EX = s0sel[k];
      @(negedge clk);
      n_chk++; if (src0 !== s0exp[k]) $display("FAIL imm_src0_%0d: got %h exp %h", k, src0, s0exp[k]); else n_pass++;
    end
    n_chk++; if (src1 !== 17'h1FFF0) $display("FAIL imm_lhb: got %h exp 1fff0", src1); else n_pass++;
    tick();
    idle(); rs0_addr = 1; rs0_re = 1; p0 = 17'h00777; tick();
    idle(); tick();
    @(negedge clk);
    n_chk++; if (p0_EX_DM !== 17'h00777) $display("FAIL st_pipe: got %h exp 00777", p0_EX_DM); else n_pass++;
    tick();
    idle(); rs0_addr = 1; rs0_re = 1; p0 = 17'h00555; tick();
    idle(); rst = 1; stall_ID_EX = 1; tick(); rst = 0;
    @(negedge clk);
    n_chk++; if (p0_EX_DM !== 17'h0) $display("FAIL rst_st: got %h exp 0", p0_EX_DM); else n_pass++;
    n_chk++; if (src0 !== 17'h0) $display("FAIL rst_src0: got %h exp 0", src0); else n_pass++;
    tick();
  endtask

  task automatic test_random();
    logic [3:0]  m_rs [2];
    logic        m_re [2];
    logic [16:0] m_p  [2];
    logic [16:0] m_st;
    logic [3:0]  ra [2];
    logic        re [2];
    logic [16:0] pd [2];
    logic [16:0] e_op [2];
    logic [1:0]  e_fwd [2];
    logic        mex [2];
    logic        mdm;
    logic        e_hz;
    logic [16:0] e_s0, e_s1;
    idle(); rst = 1; tick(); rst = 0;
    for (int i = 0; i < 2; i++) begin m_rs[i] = 0; m_re[i] = 0; m_p[i] = 0; end
    m_st = 0;
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 60) == 0);
      stall_ID_EX = ($urandom_range(0, 3) == 0);
      stall_EX_DM = ($urandom_range(0, 4) == 0);
      flush_ID_EX = ($urandom_range(0, 5) == 0);
      rs0_addr = 4'($urandom_range(0, 3)); rs1_addr = 4'($urandom_range(0, 3));
      rs0_re = 1'($urandom); rs1_re = 1'($urandom);
      p0 = 17'($urandom); p1 = 17'($urandom); pc_ID_EX = 17'($urandom);
      src0sel_ID_EX = 2'($urandom); src1sel_ID_EX = 2'($urandom); imm_ID_EX = 12'($urandom);
      dst_EX_DM = 17'($urandom); dst_DM_WB = 17'($urandom);
      dst_addr_EX_DM = 4'($urandom_range(0, 3)); dst_addr_DM_WB = 4'($urandom_range(0, 3));
      we_EX_DM = 1'($urandom); we_DM_WB = 1'($urandom); ld_EX_DM = ($urandom_range(0, 3) == 0);
      @(negedge clk);
      ra = '{rs0_addr, rs1_addr}; re = '{rs0_re, rs1_re}; pd = '{p0, p1};
      for (int i = 0; i < 2; i++) begin
        mex[i] = m_re[i] && we_EX_DM && dst_addr_EX_DM == m_rs[i] && m_rs[i] != 0;
        mdm    = m_re[i] && we_DM_WB && dst_addr_DM_WB == m_rs[i] && m_rs[i] != 0;
        if (mex[i] && !ld_EX_DM) begin e_op[i] = dst_EX_DM; e_fwd[i] = 2'd1; end
        else if (mdm)            begin e_op[i] = dst_DM_WB; e_fwd[i] = 2'd2; end
        else                     begin e_op[i] = m_p[i];    e_fwd[i] = 2'd0; end
      end
      e_hz = ld_EX_DM && (mex[0] || mex[1]);
      case (src0sel_ID_EX)
        2'd0: e_s0 = e_op[0];
        2'd1: e_s0 = sx(imm_ID_EX, 9);
        2'd2: e_s0 = sx(imm_ID_EX, 12);
        default: e_s0 = sx(imm_ID_EX, 4);
      endcase
      case (src1sel_ID_EX)
        2'd0: e_s1 = e_op[1];
        2'd1: e_s1 = pc_ID_EX;
        2'd2: e_s1 = sx(imm_ID_EX, 4);
        default: e_s1 = sx(imm_ID_EX, 8);
      endcase
      n_chk++; if (load_use_hz !== e_hz) $display("FAIL rnd_hz c%0d: got %b exp %b", c, load_use_hz, e_hz); else n_pass++;
      n_chk++; if ({fwd0, fwd1} !== {e_fwd[0], e_fwd[1]}) $display("FAIL rnd_fwd c%0d: got %b exp %b", c, {fwd0, fwd1}, {e_fwd[0], e_fwd[1]}); else n_pass++;
      n_chk++; if (p0_EX_DM !== m_st) $display("FAIL rnd_st c%0d: got %h exp %h", c, p0_EX_DM, m_st); else n_pass++;
      if (!e_hz) begin
        n_chk++; if (src0 !== e_s0) $display("FAIL rnd_src0 c%0d: got %h exp %h", c, src0, e_s0); else n_pass++;
        n_chk++; if (src1 !== e_s1) $display("FAIL rnd_src1 c%0d: got %h exp %h", c, src1, e_s1); else n_pass++;
      end
      // advance the model to the state after the coming edge
      if (rst) m_st = 0; else if (!stall_EX_DM) m_st = e_op[0];
      for (int i = 0; i < 2; i++) begin
        if (rst) begin m_rs[i] = 0; m_re[i] = 0; m_p[i] = 0; end
        else if (stall_ID_EX) begin
          if (m_re[i] && we_DM_WB && dst_addr_DM_WB == m_rs[i] && m_rs[i] != 0) m_p[i] = dst_DM_WB;
        end else if (flush_ID_EX) begin m_rs[i] = 0; m_re[i] = 0; m_p[i] = 0; end
        else begin
          m_rs[i] = ra[i]; m_re[i] = re[i];
          m_p[i] = (we_DM_WB && dst_addr_DM_WB == ra[i] && ra[i] != 0) ? dst_DM_WB : pd[i];
        end
      end
      tick();
    end
  endtask

  initial begin
    idle();
    test_reset();
    test_ex_fwd();
    test_priority();
    test_stall_refresh();
    test_load_use();
    test_zero_reg();
    test_imm_and_rst();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
